bd4_rx_fifo: RTL
================

BD4_RX_FIFO -- requirements
Module: bd4_rx_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data width of the input token and the output word.
REQ-002 Parameter DEPTH, default 4: FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_req  input  1  4-phase bundled-data request from the upstream arbitrated merge output; asynchronous to clk.
REQ-006 in_data  input  WIDTH  bundled data; stable from in_req rise until in_ack rise.
REQ-007 in_ack  output  1  4-phase acknowledge to upstream; registered.
REQ-008 out_valid  output  1  FIFO head word valid.
REQ-009 out_ready  input  1  consumer accepts head word.
REQ-010 out_data  output  WIDTH  FIFO head word.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-012 in_req SHALL pass through a 2-flop synchronizer; only the synchronized value (req_s) drives control.
REQ-013 The FSM SHALL have states DRAIN, IDLE and ACK_HI.
REQ-014 DRAIN: in_ack=0; if req_s=0, go to IDLE; otherwise stay in DRAIN.
REQ-015 IDLE: in_ack=0; if req_s=1 and a push is permitted, write in_data at wr_ptr, set in_ack=1 and go to ACK_HI; otherwise stay in IDLE.
REQ-016 Push permitted: count<DEPTH, or count==DEPTH with a pop in the same cycle.
REQ-017 ACK_HI: in_ack=1; if req_s=0, clear in_ack and go to IDLE; otherwise stay in ACK_HI.
REQ-018 Exactly one FIFO write SHALL occur per 4-phase token; no write in DRAIN or ACK_HI.
REQ-019 Latency: in_req rise to in_ack rise = 3 clk edges when not full.
REQ-019a Latency: in_req fall to in_ack fall = 3 clk edges.
REQ-020 Full FIFO: in_ack stays 0 (upstream stalls) until a pop frees an entry.
REQ-021 out_valid SHALL equal (count!=0); out_data SHALL equal mem[rd_ptr]; out_data is don't-care when out_valid=0.
REQ-022 Pop occurs when out_valid and out_ready are both 1; rd_ptr advances by 1 modulo DEPTH.
REQ-022a A push advances wr_ptr by 1 modulo DEPTH.
REQ-023 Simultaneous push and pop: count unchanged, and both pointers advance.
REQ-023a Push only: count+1. Pop only: count-1.
REQ-024 Order SHALL be strict FIFO; no word is dropped or duplicated.
REQ-025 out_ready=1 with count=0 SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force in_ack=0, count=0, out_valid=0, wr_ptr=rd_ptr=0, synchronizer flops=0 and state=DRAIN.
REQ-027 FIFO memory contents are not reset.
REQ-028 Reset asserted mid-handshake (ACK_HI with in_req high): after release, DRAIN absorbs the in-flight req without a second write. Upstream completes its return-to-zero before sending a new token.
REQ-029 After rst_n rises with in_req=0, the block SHALL reach IDLE within 3 clk edges.

Verification
REQ-030 Single token: reset, in_data=8'h2A, in_req rise -> in_ack=1 on the 3rd edge; count=1, out_valid=1, out_data=8'h2A. After in_req falls, in_ack=0 on the 3rd edge.
REQ-031 Fill to full: out_ready=0, send 8'h01..8'h04 -> count=4; a 5th token 8'h05 -> in_ack stays 0 for 20 cycles. Then out_ready=1 for 1 cycle -> 8'h01 popped, 8'h05 accepted, count=4.
REQ-032 Wrap-around: stream 10 tokens 8'h10..8'h19 with out_ready=1 continuously -> output sequence exactly 8'h10..8'h19; count never exceeds DEPTH.
REQ-033 Simultaneous push and pop at count=2 -> count stays 2; output order preserved.
REQ-034 Reset mid-handshake: assert rst_n=0 while in ACK_HI with in_req=1 -> in_ack=0 immediately and count=0. After release with in_req still 1, no write occurs (count=0). After in_req falls and a new token 8'h55 is sent, count=1 and out_data=8'h55.
REQ-035 Upstream merge driven with 32 random A/B token pairs -> 64 words received; the multiset of received words equals the multiset sent, and each source's words appear in its own send order.

Source files
------------

// File: rtl/bd4_rx_fifo_if.sv
// Bus bundle for bd4_rx_fifo: 4-phase bundled-data input side and
// valid/ready output side, plus the occupancy report.
interface bd4_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     in_req;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ack;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [$clog2(DEPTH):0]   count;

  // Upstream producer / downstream consumer side
  modport master (
    output in_req, in_data, out_ready,
    input  in_ack, out_valid, out_data, count
  );

  // FIFO side
  modport slave (
    input  in_req, in_data, out_ready,
    output in_ack, out_valid, out_data, count
  );
endinterface

// File: rtl/bd4_rx_fifo.sv
// Receive FIFO fed by a 4-phase bundled-data handshake (asynchronous to
// clk) and drained by a valid/ready consumer.
//
// state  | meaning
// DRAIN  | after reset: wait for synchronizer to settle and req to be low
// IDLE   | ack low, waiting for a request and room to write
// ACK_HI | word written, ack high, waiting for req return-to-zero
module bd4_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  bd4_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {DRAIN, IDLE, ACK_HI} state_t;

  state_t           state, state_nx;
  logic             sync1, req_s;
  logic [1:0]       settle;
  logic             ack, ack_nx;
  logic             push, pop, push_ok;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  assign pop     = (cnt != '0) && bus.out_ready;
  assign push_ok = (cnt != CW'(DEPTH)) || pop;

  // Two-flop synchronizer for the asynchronous request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      req_s <= 1'b0;
    end else begin
      sync1 <= bus.in_req;
      req_s <= sync1;
    end
  end

  // Settle timer: the reset value of the synchronizer is not the real
  // request level, so DRAIN must not trust req_s until it has refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) settle <= 2'd2;
    else if (settle != 2'd0) settle <= settle - 2'd1;
  end

  // FSM state and registered acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DRAIN;
      ack   <= 1'b0;
    end else begin
      state <= state_nx;
      ack   <= ack_nx;
    end
  end

  // Next-state, next-ack and push decision
  always_comb begin
    state_nx = state;
    ack_nx   = 1'b0;
    push     = 1'b0;
    case (state)
      DRAIN: begin
        if (settle == 2'd0 && !req_s) state_nx = IDLE;
      end
      IDLE: begin
        if (req_s && push_ok) begin
          push     = 1'b1;
          ack_nx   = 1'b1;
          state_nx = ACK_HI;
        end
      end
      ACK_HI: begin
        ack_nx = 1'b1;
        if (!req_s) begin
          ack_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = DRAIN;
    endcase
  end

  // Storage; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.in_ack    = ack;
  assign bus.out_valid = (cnt != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = cnt;
endmodule
